// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types for the Z80 bus responder.
// FSM state encoding, bus cycle classification and the wait-state count type.
package z80_bus_pkg;

  // Responder FSM state, exposed on the debug port of the top.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_REQ  = 3'd1;
  localparam state_t ST_CAPT = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // Classified CPU bus cycle.
  typedef enum logic [2:0] {
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_INTACK,
    CYC_ILLEGAL
  } cycle_e;

  // Number of extra wait states (0..15).
  typedef logic [3:0] wait_cnt_t;

  // True when exactly one of the active-low read/write strobes is asserted.
  function automatic logic one_strobe(input logic rd_n, input logic wr_n);
    return rd_n ^ wr_n;
  endfunction

endpackage

// File: rtl/z80_bus_responder_wait_gen.sv
// z80_wait_gen: loadable down-counter for inserted wait states.
// Loaded with the wait count on entry to the wait phase; done_o rises on the
// clock in which the last wait state is being spent, so the FSM leaves WAIT
// after exactly load_val_i cycles.
module z80_wait_gen
  import z80_bus_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      load_i,
  input  logic      en_i,
  input  wait_cnt_t load_val_i,
  output logic      done_o
);

  wait_cnt_t cnt_q;

  // Count down while enabled; a load always wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q <= 4'd1);

endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: converts Z80 bus cycles into single-pulse requests on a
// synchronous memory port or I/O port, drives cpu_di and stretches the CPU
// cycle with wait_n.
// Optional feature: define Z80_BUS_RESP_INTACK_EN to service interrupt
// acknowledge cycles (intack pulse, int_vector on cpu_di); otherwise INTACK
// is treated as an illegal cycle.
//
// Handshake: a request strobe (mem_re/mem_we/io_re/io_we/intack) is a
// one-clock pulse with address/data stable while it is high; read data is
// expected on the matching rdata input exactly one clock after the pulse.
// Towards the CPU, wait_n stays low from classification until the read data
// is captured and all wait states have elapsed.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter wait_cnt_t  MEM_WAIT  = 4'd0,
  parameter wait_cnt_t  IO_WAIT   = 4'd1,
  parameter logic [7:0] IDLE_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_re,
  output logic        io_we,
  input  logic [7:0]  io_rdata,
  input  logic [7:0]  int_vector,
  output logic        intack,
  output state_t      dbg_state_o
);

  state_t      state_q, state_d;
  cycle_e      cyc_q, cyc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cpu_di_q, cpu_di_d;

  logic        is_refresh, is_mem, is_io, is_intack, is_illegal;
  wait_cnt_t   wait_load;
  logic        wait_done;

  // Classify the sampled strobes; refresh is checked first so it never
  // becomes a request, and MEM is checked before IO to give it priority.
  always_comb begin
    is_refresh = !mreq_n && !rfsh_n;
    is_illegal = (!mreq_n || !iorq_n) && !rd_n && !wr_n;
    is_mem     = !mreq_n && rfsh_n && one_strobe(rd_n, wr_n);
    is_intack  = !iorq_n && !m1_n;
    is_io      = !iorq_n && m1_n && one_strobe(rd_n, wr_n);
  end

  // I/O and INTACK cycles use the I/O wait count, memory cycles the memory one.
  always_comb begin
    wait_load = MEM_WAIT;
    if ((cyc_q == CYC_IO_RD) || (cyc_q == CYC_IO_WR) || (cyc_q == CYC_INTACK)) begin
      wait_load = IO_WAIT;
    end
  end

  // Next-state logic for the responder FSM and its latched cycle context.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cpu_di_d = cpu_di_q;
    case (state_q)
      ST_IDLE: begin
        if (is_refresh) begin
          state_d = ST_IDLE;
        end else if (is_illegal) begin
          cyc_d    = CYC_ILLEGAL;
          cpu_di_d = IDLE_DATA;
          state_d  = ST_DONE;
        end else if (is_mem) begin
          cyc_d   = rd_n ? CYC_MEM_WR : CYC_MEM_RD;
          addr_d  = cpu_a;
          wdata_d = cpu_do;
          state_d = ST_REQ;
        end else if (is_intack) begin
`ifdef Z80_BUS_RESP_INTACK_EN
          cyc_d   = CYC_INTACK;
          addr_d  = cpu_a;
          state_d = ST_REQ;
`else
          cyc_d    = CYC_ILLEGAL;
          cpu_di_d = IDLE_DATA;
          state_d  = ST_DONE;
`endif
        end else if (is_io) begin
          cyc_d   = rd_n ? CYC_IO_WR : CYC_IO_RD;
          addr_d  = cpu_a;
          wdata_d = cpu_do;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        case (cyc_q)
          CYC_MEM_RD: cpu_di_d = mem_rdata;
          CYC_IO_RD:  cpu_di_d = io_rdata;
`ifdef Z80_BUS_RESP_INTACK_EN
          CYC_INTACK: cpu_di_d = int_vector;
`endif
          default:    cpu_di_d = cpu_di_q;
        endcase
        state_d = (wait_load == '0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Hold until the CPU ends its cycle so one cycle gives one request.
        if (mreq_n && iorq_n) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and cycle-context registers; reset abandons any pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= CYC_ILLEGAL;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_di_q <= IDLE_DATA;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cpu_di_q <= cpu_di_d;
    end
  end

  z80_wait_gen u_wait_gen (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (state_q == ST_CAPT),
    .en_i       (state_q == ST_WAIT),
    .load_val_i (wait_load),
    .done_o     (wait_done)
  );

  // Strobes are decoded from registered state so reset drops them at once.
  always_comb begin
    mem_re = (state_q == ST_REQ) && (cyc_q == CYC_MEM_RD);
    mem_we = (state_q == ST_REQ) && (cyc_q == CYC_MEM_WR);
    io_re  = (state_q == ST_REQ) && (cyc_q == CYC_IO_RD);
    io_we  = (state_q == ST_REQ) && (cyc_q == CYC_IO_WR);
`ifdef Z80_BUS_RESP_INTACK_EN
    intack = (state_q == ST_REQ) && (cyc_q == CYC_INTACK);
`else
    intack = 1'b0;
`endif
    wait_n = !((state_q == ST_REQ) || (state_q == ST_CAPT) || (state_q == ST_WAIT));
  end

`ifndef Z80_BUS_RESP_INTACK_EN
  logic unused_int_vector;
  assign unused_int_vector = ^int_vector;
`endif

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign io_addr     = addr_q[7:0];
  assign io_wdata    = wdata_q;
  assign cpu_di      = cpu_di_q;
  assign dbg_state_o = state_q;

endmodule
